// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter in front of one shared restoring divider.
// Several filter stages request a division; one is granted at a time, the
// divider runs one quotient bit per cycle, and the result is held for the
// owning requester until it accepts it.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   req_valid / req_ready        per-requester request handshake
//   req_dividend / req_divisor   packed operands, requester i at slot i
//   rsp_valid / rsp_ready        per-requester response handshake
//   rsp_quotient                 shared quotient bus
//   rsp_pixel                    quotient saturated to 8 bits
//   rsp_div_zero                 result came from a zero divisor
//   busy                         controller not idle
//
// state   | meaning
// IDLE    | arbitrate, accept one request
// DIVIDE  | one quotient bit per cycle, MSB first
// RESPOND | hold result until the owner accepts it
module div_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]    req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]     req_divisor,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic [DIVIDEND_WIDTH-1:0]            rsp_quotient,
  output logic [7:0]                           rsp_pixel,
  output logic                                 rsp_div_zero,
  output logic                                 busy
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVIDE  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t         state_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  owner_q;
  logic [CW-1:0]  cnt_q;
  logic [DW-1:0]  dividend_q;
  logic [DW-1:0]  quotient_q;
  logic [VW-1:0]  divisor_q;
  logic [VW:0]    rem_q;
  logic           div_zero_q;

  logic           grant_found;
  logic [IW-1:0]  grant_idx;
  logic [DW-1:0]  sel_dividend;
  logic [VW-1:0]  sel_divisor;
  logic [VW+1:0]  rem_shift;
  logic           rem_ge;

  // Round-robin: lowest valid index at or above ptr, otherwise lowest valid
  // index overall (which is then necessarily below ptr, i.e. the wrap).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IW'(i) >= ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = IW'(i);
      end
    end
    if (!grant_found) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == grant_idx) begin
        sel_dividend = req_dividend[i*DW +: DW];
        sel_divisor  = req_divisor[i*VW +: VW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESPOND) rsp_valid[owner_q] = 1'b1;
  end

  // Partial remainder shifted left with the next dividend bit brought in.
  assign rem_shift = {rem_q, dividend_q[DW-1]};
  assign rem_ge    = (rem_shift >= {2'b00, divisor_q});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quotient_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            owner_q    <= grant_idx;
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            rem_q      <= '0;
            cnt_q      <= CW'(DW - 1);
            if (sel_divisor == '0) begin
              quotient_q <= '1;
              div_zero_q <= 1'b1;
              state_q    <= RESPOND;
            end else begin
              quotient_q <= '0;
              div_zero_q <= 1'b0;
              state_q    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          dividend_q <= dividend_q << 1;
          rem_q      <= rem_ge ? (VW+1)'(rem_shift - {2'b00, divisor_q})
                               : (VW+1)'(rem_shift);
          quotient_q <= {quotient_q[DW-2:0], rem_ge};
          cnt_q      <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready[owner_q]) begin
            ptr_q   <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_quotient = quotient_q;
  assign rsp_pixel    = (quotient_q > DW'(255)) ? 8'hFF : quotient_q[7:0];
  assign rsp_div_zero = div_zero_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter. Expected results are pushed
// to a scoreboard when a request is granted and popped when the response
// appears. Covers reset state, contention and pointer wrap, zero divisor,
// saturation with backpressure, and reset during a division.
module tb_div_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int VW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_dividend;
  logic [N*VW-1:0]   req_divisor;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_quotient;
  logic [7:0]        rsp_pixel;
  logic              rsp_div_zero;
  logic              busy;

  div_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_pixel(rsp_pixel),
    .rsp_div_zero(rsp_div_zero), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            owner;
    logic [DW-1:0] quot;
    logic          dz;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] dvd_in [N];
  logic [VW-1:0] dvs_in [N];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_req(input int r, input logic v, input logic [DW-1:0] a, input logic [VW-1:0] b);
    req_valid[r]              = v;
    req_dividend[r*DW +: DW]  = a;
    req_divisor[r*VW +: VW]   = b;
    dvd_in[r]                 = a;
    dvs_in[r]                 = b;
  endtask

  // Wait (bounded) for a grant, check it went to r, record the expected result.
  task automatic expect_grant(input int r);
    int   w;
    exp_t e;
    w = 0;
    #1;
    while (req_ready == '0 && w < 40) begin
      cyc();
      #1;
      w++;
    end
    check("grant", 32'(req_ready), 32'(1 << r));
    e.owner = r;
    e.dz    = (dvs_in[r] == '0);
    e.quot  = e.dz ? '1 : dvd_in[r] / DW'(dvs_in[r]);
    sb.push_back(e);
    cyc();
    req_valid[r] = 1'b0;
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, stall
  // for 'stall' cycles with only the non-owner ready, then accept.
  task automatic complete(input int stall);
    int         lat;
    exp_t       e;
    logic [7:0] px;
    lat = 0;
    #1;
    while (rsp_valid == '0 && lat < 40) begin
      cyc();
      #1;
      lat++;
    end
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e  = sb.pop_front();
    px = (e.quot > 16'd255) ? 8'hFF : e.quot[7:0];
    check("latency",   32'(lat), e.dz ? 32'd0 : 32'(DW));
    check("rsp_valid", 32'(rsp_valid), 32'(1 << e.owner));
    check("quotient",  32'(rsp_quotient), 32'(e.quot));
    check("pixel",     32'(rsp_pixel), 32'(px));
    check("div_zero",  32'(rsp_div_zero), 32'(e.dz));
    check("busy_rsp",  32'(busy), 32'd1);
    repeat (stall) begin
      rsp_ready = '0;
      rsp_ready[1 - e.owner] = 1'b1;
      cyc();
      #1;
      check("stall_valid", 32'(rsp_valid), 32'(1 << e.owner));
      check("stall_quot",  32'(rsp_quotient), 32'(e.quot));
      check("stall_pixel", 32'(rsp_pixel), 32'(px));
      check("stall_busy",  32'(busy), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = '0;
    rsp_ready[e.owner] = 1'b1;
    cyc();
    rsp_ready = '0;
    #1;
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = '0;
    for (int i = 0; i < N; i++) begin
      dvd_in[i] = '0;
      dvs_in[i] = '0;
    end
    repeat (2) @(negedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_quotient",  32'(rsp_quotient), 32'd0);
    check("rst_pixel",     32'(rsp_pixel), 32'd0);
    check("rst_div_zero",  32'(rsp_div_zero), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Contention out of reset: req0 first, then req1.
    set_req(0, 1'b1, 16'd3825, 8'd85);
    set_req(1, 1'b1, 16'd5000, 8'd7);
    expect_grant(0);
    complete(0);
    expect_grant(1);
    complete(0);

    // Pointer wrapped to 0: req0 again, then req1 with a zero divisor.
    set_req(0, 1'b1, 16'd100, 8'd3);
    set_req(1, 1'b1, 16'd1000, 8'd0);
    expect_grant(0);
    complete(0);
    expect_grant(1);
    complete(0);

    // Saturation with backpressure.
    set_req(0, 1'b1, 16'd65535, 8'd1);
    expect_grant(0);
    complete(5);

    // Reset during cycle 8 of DIVIDE aborts the operation.
    set_req(1, 1'b1, 16'd1000, 8'd3);
    expect_grant(1);
    repeat (7) cyc();
    reset = 1'b1;
    #1;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_quot",  32'(rsp_quotient), 32'd0);
    sb.delete();
    cyc();
    reset = 1'b0;
    repeat (20) begin
      cyc();
      #1;
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // After reset ptr is 0 again: req0 wins over req1.
    set_req(0, 1'b1, 16'd200, 8'd7);
    set_req(1, 1'b1, 16'd50, 8'd5);
    expect_grant(0);
    complete(0);
    expect_grant(1);
    complete(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
